intt_sdf_stage: RTL and testbench

INTT_SDF_STAGE -- requirements
Module: intt_sdf_stage

---
 rtl/intt_sdf_stage.sv | 146 ++++++++++++++
 tb/tb_intt_sdf_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_sdf_stage.sv
// Single-path delay-feedback stage of a radix-2 inverse NTT (DIT butterfly).
// Samples stream in natural order; sums leave at once, differences after DELAY samples.
module intt_sdf_stage #(
    parameter int W       = 32,
    parameter int MODULUS = 7681,
    parameter int DELAY   = 4,
    parameter int HALVE   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_twiddle,
    input  logic         flush,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy
);

    // state   | meaning
    // S_FILL  | first half of a block (x) goes into the delay line, no output
    // S_BFLY  | second half (y): emit x+y*w, park x-y*w in the delay line
    // S_PASS  | emit parked differences while the next block's x fills in
    // S_DRAIN | flush: emit parked differences with no new input
    typedef enum logic [1:0] {S_FILL, S_BFLY, S_PASS, S_DRAIN} state_t;

    localparam int             CW       = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [W-1:0]   Q        = W'(MODULUS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DELAY - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [W-1:0]    dl_q [DELAY];
    logic [W-1:0]    dl_d [DELAY];

    logic            accept, shift, wrap, produce;
    logic [W-1:0]    x_red, w_red, t, head, sum_raw, sum, diff, wr_val, prod_val;
    logic [2*W-1:0]  prod;

    // Operands are below 2^(W/2), so sums of two residues never overflow W bits.
    function automatic logic [W-1:0] halve_mod(input logic [W-1:0] v);
        if (HALVE == 0)
            return v;
        else if (!v[0])
            return v >> 1;
        else
            return (v + Q) >> 1;
    endfunction

    always_comb begin
        x_red   = in_data % Q;
        w_red   = in_twiddle % Q;
        prod    = {{W{1'b0}}, x_red} * {{W{1'b0}}, w_red};
        t       = W'(prod % {{W{1'b0}}, Q});
        head    = dl_q[DELAY-1];
        sum_raw = head + t;
        sum     = (sum_raw >= Q) ? sum_raw - Q : sum_raw;
        diff    = (head >= t) ? head - t : head + Q - t;
    end

    always_comb begin
        accept      = in_valid && (state_q != S_DRAIN);
        shift       = accept || (state_q == S_DRAIN);
        wrap        = shift && (cnt_q == CNT_LAST);
        state_d     = state_q;
        cnt_d       = cnt_q;
        produce     = 1'b0;
        prod_val    = '0;
        wr_val      = x_red;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (shift)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_FILL: begin
                if (wrap)
                    state_d = S_BFLY;
            end
            S_BFLY: begin
                if (accept) begin
                    produce  = 1'b1;
                    prod_val = sum;
                    wr_val   = diff;
                end
                if (wrap)
                    state_d = S_PASS;
            end
            S_PASS: begin
                if (accept) begin
                    produce  = 1'b1;
                    prod_val = head;
                end
                if (wrap)
                    state_d = S_BFLY;
                else if (cnt_q == '0 && flush && !in_valid)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                produce  = 1'b1;
                prod_val = head;
                wr_val   = '0;
                if (wrap)
                    state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase

        if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = halve_mod(prod_val);
        end

        dl_d[0] = wr_val;
        for (int i = 1; i < DELAY; i++)
            dl_d[i] = dl_q[i-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Delay line is deliberately unreset; S_FILL always rewrites it before it is read.
    always_ff @(posedge clk) begin
        if (shift)
            dl_q <= dl_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = !(state_q == S_FILL && cnt_q == '0);

endmodule

// File: tb/tb_intt_sdf_stage.sv
// Directed bench for intt_sdf_stage: DELAY=1 instances with and without halving,
// plus a DELAY=4 instance checked against a software DIT reference.
module tb_intt_sdf_stage;
    localparam int W = 32;
    localparam int Q = 7681;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] in_twiddle = '0;

    logic         ov_a, ov_b, ov4;
    logic [W-1:0] od_a, od_b, od4;
    logic         busy_a, busy_b, busy4;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q4[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sd[24];
    logic [W-1:0] sw[24];

    intt_sdf_stage #(.W(W), .MODULUS(Q), .DELAY(1), .HALVE(0)) u_d1h0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_twiddle(in_twiddle), .flush(flush), .out_valid(ov_a),
        .out_data(od_a), .busy(busy_a));

    intt_sdf_stage #(.W(W), .MODULUS(Q), .DELAY(1), .HALVE(1)) u_d1h1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_twiddle(in_twiddle), .flush(flush), .out_valid(ov_b),
        .out_data(od_b), .busy(busy_b));

    intt_sdf_stage #(.W(W), .MODULUS(Q), .DELAY(4), .HALVE(1)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_twiddle(in_twiddle), .flush(flush), .out_valid(ov4),
        .out_data(od4), .busy(busy4));

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst && ov4)
            q4.push_back(od4);

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic [W-1:0] w,
                        input logic f);
        in_valid   = v;
        in_data    = d;
        in_twiddle = w;
        flush      = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q4.delete();
    endtask

    // Reference: value * 2^-1 mod q, computed by multiplying with (q+1)/2.
    function automatic logic [W-1:0] ref_h(input longint v);
        return W'((v * longint'((Q + 1) / 2)) % Q);
    endfunction

    // Expected DELAY=4 stream for nblk blocks starting at index base: sums then diffs per block.
    task automatic build_exp(input int base, input int nblk);
        longint x, y, w, tt;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 4; j++) begin
                x  = longint'(sd[base + 8*b + j]) % Q;
                y  = longint'(sd[base + 8*b + 4 + j]) % Q;
                w  = longint'(sw[base + 8*b + 4 + j]) % Q;
                tt = (y * w) % Q;
                exp_q.push_back(ref_h(x + tt));
            end
            for (int j = 0; j < 4; j++) begin
                x  = longint'(sd[base + 8*b + j]) % Q;
                y  = longint'(sd[base + 8*b + 4 + j]) % Q;
                w  = longint'(sw[base + 8*b + 4 + j]) % Q;
                tt = (y * w) % Q;
                exp_q.push_back(ref_h(x - tt + Q));
            end
        end
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (q4.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d outputs, expected %0d", name, q4.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q4.size(); i++) begin
            checks++;
            if (q4[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s[%0d]: got %0d, expected %0d", name, i, q4[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        in_valid   = 1'b1;
        in_data    = 32'd77;
        in_twiddle = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        checks += 9;
        if (ov_a !== 1'b0)  begin failures++; $display("FAIL reset_ov_a: got %b, expected 0", ov_a); end
        if (od_a !== '0)    begin failures++; $display("FAIL reset_od_a: got %0d, expected 0", od_a); end
        if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a: got %b, expected 0", busy_a); end
        if (ov_b !== 1'b0)  begin failures++; $display("FAIL reset_ov_b: got %b, expected 0", ov_b); end
        if (od_b !== '0)    begin failures++; $display("FAIL reset_od_b: got %0d, expected 0", od_b); end
        if (busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy_b: got %b, expected 0", busy_b); end
        if (ov4 !== 1'b0)   begin failures++; $display("FAIL reset_ov4: got %b, expected 0", ov4); end
        if (od4 !== '0)     begin failures++; $display("FAIL reset_od4: got %0d, expected 0", od4); end
        if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4: got %b, expected 0", busy4); end
        in_valid = 1'b0;
        rst = 1'b1;
        step(0, 0, 0, 0);
    endtask

    // One DELAY=1 block with x, y, w; checks sum/diff on both halving variants.
    task automatic run_d1(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] w, input logic [W-1:0] ea_s,
                          input logic [W-1:0] ea_d, input logic [W-1:0] eb_s,
                          input logic [W-1:0] eb_d);
        do_reset();
        step(1, x, 32'd999, 0);
        checks += 2;
        if (ov_a !== 1'b0) begin failures++; $display("FAIL %s_fill_ov: got %b, expected 0", name, ov_a); end
        if (busy_a !== 1'b1) begin failures++; $display("FAIL %s_fill_busy: got %b, expected 1", name, busy_a); end
        step(1, y, w, 0);
        checks += 4;
        if (ov_a !== 1'b1) begin failures++; $display("FAIL %s_sum_ov: got %b, expected 1", name, ov_a); end
        if (od_a !== ea_s) begin failures++; $display("FAIL %s_sum_h0: got %0d, expected %0d", name, od_a, ea_s); end
        if (od_b !== eb_s) begin failures++; $display("FAIL %s_sum_h1: got %0d, expected %0d", name, od_b, eb_s); end
        if (busy_a !== 1'b1) begin failures++; $display("FAIL %s_pass_busy: got %b, expected 1", name, busy_a); end
        step(0, 0, 0, 1);
        checks += 2;
        if (ov_a !== 1'b0) begin failures++; $display("FAIL %s_flush_ov: got %b, expected 0", name, ov_a); end
        if (od_a !== ea_s) begin failures++; $display("FAIL %s_hold: got %0d, expected %0d", name, od_a, ea_s); end
        step(0, 0, 0, 0);
        checks += 4;
        if (ov_a !== 1'b1) begin failures++; $display("FAIL %s_drain_ov: got %b, expected 1", name, ov_a); end
        if (od_a !== ea_d) begin failures++; $display("FAIL %s_diff_h0: got %0d, expected %0d", name, od_a, ea_d); end
        if (od_b !== eb_d) begin failures++; $display("FAIL %s_diff_h1: got %0d, expected %0d", name, od_b, eb_d); end
        if (busy_a !== 1'b0) begin failures++; $display("FAIL %s_end_busy: got %b, expected 0", name, busy_a); end
        step(0, 0, 0, 0);
        checks += 1;
        if (ov_b !== 1'b0) begin failures++; $display("FAIL %s_idle_ov: got %b, expected 0", name, ov_b); end
    endtask

    task automatic test_d1_basic();
        // 5 + 3*2 = 11; 5 - 6 = -1 = 7680; halved: (11+7681)/2 = 3846, 7680/2 = 3840
        run_d1("d1", 32'd5, 32'd3, 32'd2, 32'd11, 32'd7680, 32'd3846, 32'd3840);
    endtask

    task automatic test_reduce();
        // x = 3q+10 -> 10, y = q+2 -> 2, w = 2q+1 -> 1: sum 12, diff 8; halved 6, 4
        run_d1("reduce", 32'(3*Q + 10), 32'(Q + 2), 32'(2*Q + 1), 32'd12, 32'd8, 32'd6, 32'd4);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 24; i++) begin
            sd[i] = 32'($urandom_range(0, Q - 1));
            sw[i] = 32'($urandom_range(0, Q - 1));
        end
        sd[5] = 32'(Q - 1);
        sw[5] = 32'(Q - 1);
        build_exp(0, 3);
        do_reset();
        for (int i = 0; i < 24; i++)
            step(1, sd[i], sw[i], 0);
        step(0, 0, 0, 1);
        repeat (8) step(0, 0, 0, 0);
        compare_stream("stream");
        checks++;
        if (busy4 !== 1'b0) begin failures++; $display("FAIL stream_busy: got %b, expected 0", busy4); end
    endtask

    task automatic test_gaps();
        int g;
        logic fl;
        build_exp(0, 3);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            g  = (i % 4 == 0) ? 6 : int'($urandom_range(0, 2));
            fl = !((i % 8 == 0) && (i >= 8));
            for (int k = 0; k < g; k++)
                step(0, 32'($urandom_range(0, Q - 1)), 32'd1, fl);
            step(1, sd[i], sw[i], 0);
        end
        step(0, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            step(1, 32'd1234, 32'd5, 0);
        repeat (4) step(0, 0, 0, 0);
        compare_stream("gaps");
        checks++;
        if (busy4 !== 1'b0) begin failures++; $display("FAIL gaps_busy: got %b, expected 0", busy4); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, 32'(100 * (i + 1)), 32'd0, 0);
        step(1, 32'd11, 32'd13, 0);
        step(1, 32'd12, 32'd14, 0);
        #2;
        rst = 1'b0;
        #1;
        checks += 2;
        if (ov4 !== 1'b0) begin failures++; $display("FAIL midrst_ov: got %b, expected 0", ov4); end
        if (busy4 !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, expected 0", busy4); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        q4.delete();
        for (int i = 0; i < 8; i++) begin
            sd[i] = 32'(3000 + 97 * i);
            sw[i] = 32'(7 + 1000 * i);
        end
        build_exp(0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, sd[i], sw[i], 0);
            checks++;
            if (ov4 !== 1'b0) begin failures++; $display("FAIL midrst_fill_ov[%0d]: got %b, expected 0", i, ov4); end
        end
        for (int i = 4; i < 8; i++)
            step(1, sd[i], sw[i], 0);
        step(0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0);
        compare_stream("midrst");
    endtask

    initial begin
        #3;
        test_reset();
        test_d1_basic();
        test_reduce();
        test_stream();
        test_gaps();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
